// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches under a credit limit,
// and buffers returned words for decode. Optional IFU_BYPASS_EN forwards a response straight to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_mem_req_valid,
  input  logic        ifu_mem_req_ready,
  output logic [31:0] ifu_mem_req_addr,
  input  logic        mem_ifu_rsp_valid,
  input  logic [31:0] mem_ifu_rsp_data,
  input  logic        mem_ifu_rsp_err,
  input  logic        ex_ifu_redirect,
  input  logic [31:0] ex_ifu_redirect_pc,
  output logic        ifu_id_valid,
  input  logic        id_ifu_ready,
  output logic [31:0] ifu_id_inst,
  output logic [31:0] pc_id_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [31:0]   fetch_pc, rsp_pc;

  logic [CW:0]   credit_used;
  logic          req_fire, rsp_keep, bypass, fifo_empty, push, pop;
  ent_t          rsp_ent, head;

  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign ifu_mem_req_valid = !rst && !ex_ifu_redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign ifu_mem_req_addr  = fetch_pc;
  assign req_fire = ifu_mem_req_valid && ifu_mem_req_ready;

  // A faulting fetch turns into ebreak so the fault travels down the normal trap path.
  assign rsp_keep = mem_ifu_rsp_valid && (discard == '0) && !ex_ifu_redirect;
  assign rsp_ent  = {rsp_pc, (mem_ifu_rsp_err ? EBREAK : mem_ifu_rsp_data)};

  assign fifo_empty = (count == '0);
  assign head       = fifo_q[rd_ptr];
`ifdef IFU_BYPASS_EN
  assign bypass = fifo_empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign ifu_id_valid = !fifo_empty || bypass;
  assign ifu_id_inst  = !fifo_empty ? head.inst : (bypass ? rsp_ent.inst : NOP);
  assign pc_id_pc     = !fifo_empty ? head.pc   : (bypass ? rsp_ent.pc   : 32'h0);

  assign pop  = !fifo_empty && id_ifu_ready && !ex_ifu_redirect;
  assign push = rsp_keep && !(bypass && id_ifu_ready);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= rsp_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (ex_ifu_redirect) begin
      fetch_pc    <= {ex_ifu_redirect_pc[31:2], 2'b00};
      rsp_pc      <= {ex_ifu_redirect_pc[31:2], 2'b00};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      // Everything still in flight belongs to the old path, including fetches an
      // earlier redirect already condemned, so discard covers all of outstanding.
      outstanding <= outstanding - CW'(mem_ifu_rsp_valid);
      discard     <= outstanding - CW'(mem_ifu_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
      if (mem_ifu_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_ifu_rsp_valid);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: hand-derived vector table, directed corner sequences, and a
// randomized run against a request/entry queue model of fetch, redirect and decode.
module tb_ifu_fetch;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_mem_req_valid, ifu_mem_req_ready = 1'b0;
  logic [31:0] ifu_mem_req_addr;
  logic        mem_ifu_rsp_valid = 1'b0, mem_ifu_rsp_err = 1'b0;
  logic [31:0] mem_ifu_rsp_data = 32'h0;
  logic        ex_ifu_redirect = 1'b0;
  logic [31:0] ex_ifu_redirect_pc = 32'h0;
  logic        ifu_id_valid, id_ifu_ready = 1'b0;
  logic [31:0] ifu_id_inst, pc_id_pc;

  ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ifu_mem_req_valid(ifu_mem_req_valid), .ifu_mem_req_ready(ifu_mem_req_ready),
    .ifu_mem_req_addr(ifu_mem_req_addr),
    .mem_ifu_rsp_valid(mem_ifu_rsp_valid), .mem_ifu_rsp_data(mem_ifu_rsp_data),
    .mem_ifu_rsp_err(mem_ifu_rsp_err),
    .ex_ifu_redirect(ex_ifu_redirect), .ex_ifu_redirect_pc(ex_ifu_redirect_pc),
    .ifu_id_valid(ifu_id_valid), .id_ifu_ready(id_ifu_ready),
    .ifu_id_inst(ifu_id_inst), .pc_id_pc(pc_id_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted fetch is a queue entry; a redirect marks them all stale.
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  req_t        infl[$];
  ent_t        ibuf[$];
  logic [31:0] m_pc;

  logic        s_rv, s_idv;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic model_reset();
    infl.delete();
    ibuf.delete();
    m_pc = RST_PC;
  endtask

  task automatic step(input bit rr, input bit ir, input bit rv, input bit er,
                      input bit rd, input logic [31:0] rpc);
    bit   have, keep, byp, e_rv, e_idv;
    req_t r;
    ent_t re, e_head;
    r = '{addr: 32'h0, stale: 1'b0};
    have = (infl.size() > 0);
    if (have) r = infl[0];
    ifu_mem_req_ready  = rr;
    id_ifu_ready       = ir;
    mem_ifu_rsp_valid  = rv && have;
    mem_ifu_rsp_err    = er;
    mem_ifu_rsp_data   = (rv && have) ? ~r.addr : 32'hDEAD_BEEF;
    ex_ifu_redirect    = rd;
    ex_ifu_redirect_pc = rpc;
    #1;
    s_rv = ifu_mem_req_valid; s_addr = ifu_mem_req_addr;
    s_idv = ifu_id_valid; s_inst = ifu_id_inst; s_pc = pc_id_pc;

    e_rv = !rd && (infl.size() + ibuf.size() < DEPTH);
    keep = rv && have && !rd && !r.stale;
    re.pc = r.addr;
    re.inst = er ? EBREAK : ~r.addr;
    byp = 1'b0;
`ifdef IFU_BYPASS_EN
    byp = keep && (ibuf.size() == 0);
`endif
    e_idv = (ibuf.size() > 0) || byp;
    e_head = (ibuf.size() > 0) ? ibuf[0] : (byp ? re : '{pc: 32'h0, inst: NOP});
    chk("req_valid", 32'(s_rv), 32'(e_rv));
    chk("req_addr", s_addr, m_pc);
    chk("id_valid", 32'(s_idv), 32'(e_idv));
    chk("id_inst", s_inst, e_head.inst);
    chk("id_pc", s_pc, e_head.pc);

    if (rv && have) void'(infl.pop_front());
    if (rd) begin
      ibuf.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (ibuf.size() > 0 && ir) void'(ibuf.pop_front());
      if (keep && !(byp && ir)) ibuf.push_back(re);
      if (e_rv && rr) begin
        infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_mem_req_ready = 1'b0; id_ifu_ready = 1'b0; mem_ifu_rsp_valid = 1'b0;
    ex_ifu_redirect = 1'b0; mem_ifu_rsp_err = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit rr, ir, rv, er, rd; logic [31:0] rpc;
    bit e_rv; logic [31:0] e_addr; bit e_idv; logic [31:0] e_inst, e_pc;
  } vec_t;
  vec_t vt[13];

  initial begin
    int acc;
    bit seen;
    logic [31:0] rpc;

    vt[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h8000_0000,1'b0,NOP,32'h0};
    vt[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0, 1'b1,32'h8000_0004,1'b0,NOP,32'h0};
    vt[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0, 1'b0,32'h8000_0008,1'b1,32'h7FFF_FFFF,32'h8000_0000};
    vt[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h8000_0008,1'b1,32'h7FFF_FFFB,32'h8000_0004};
    vt[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,32'h0, 1'b1,32'h8000_000C,1'b0,NOP,32'h0};
    vt[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0,32'h8000_0010,1'b1,EBREAK,32'h8000_0008};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h8000_0010,1'b1,EBREAK,32'h8000_0008};
    vt[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h8000_0010,1'b1,EBREAK,32'h8000_0008};
    vt[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'h8000_0010,1'b1,32'h7FFF_FFF3,32'h8000_000C};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h8000_0101, 1'b0,32'h8000_0014,1'b0,NOP,32'h0};
    vt[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0, 1'b1,32'h8000_0100,1'b0,NOP,32'h0};
    vt[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0, 1'b1,32'h8000_0104,1'b0,NOP,32'h0};
    vt[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'h8000_0108,1'b1,32'h7FFF_FEFF,32'h8000_0100};

    model_reset();
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(ifu_mem_req_valid), 32'h0);
    chk("rst_req_addr", ifu_mem_req_addr, RST_PC);
    chk("rst_id_valid", 32'(ifu_id_valid), 32'h0);
    chk("rst_id_inst", ifu_id_inst, NOP);
    chk("rst_id_pc", pc_id_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-derived vectors: streaming, ebreak on fault, stall, redirect to 8000_0101.
    foreach (vt[i]) begin
      step(vt[i].rr, vt[i].ir, vt[i].rv, vt[i].er, vt[i].rd, vt[i].rpc);
`ifndef IFU_BYPASS_EN
      chk($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(vt[i].e_rv));
      chk($sformatf("vec%0d_req_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_id_valid", i), 32'(s_idv), 32'(vt[i].e_idv));
      chk($sformatf("vec%0d_id_inst", i), s_inst, vt[i].e_inst);
      chk($sformatf("vec%0d_id_pc", i), s_pc, vt[i].e_pc);
`endif
    end

    // Decode stalled: credits cap the number of requests at DEPTH.
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (s_rv) acc++;
    end
    chk("stall_req_count", 32'(acc), 32'(DEPTH));
    chk("stall_head_pc", s_pc, RST_PC);
    chk("stall_head_inst", s_inst, ~RST_PC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Two outstanding, redirect: stale responses dropped, decode restarts at 8000_0100.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0101);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (s_idv) begin
        seen = 1'b1;
        chk("redir_first_pc", s_pc, 32'h8000_0100);
      end
    end
    if (!seen) chk("redir_timeout", 32'h0, 32'h1);

    // Redirect coinciding with a response and a decode pop.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_rsp_id_valid", 32'(s_idv), 32'h0);
    chk("redir_rsp_req_valid", 32'(s_rv), 32'h1);
    chk("redir_rsp_req_addr", s_addr, 32'h8000_0200);

    // Asynchronous reset with two requests outstanding.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_valid", 32'(ifu_mem_req_valid), 32'h0);
    chk("arst_req_addr", ifu_mem_req_addr, RST_PC);
    chk("arst_id_valid", 32'(ifu_id_valid), 32'h0);
    chk("arst_id_inst", ifu_id_inst, NOP);
    chk("arst_id_pc", pc_id_pc, 32'h0);
    @(negedge clk);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("arst_resume_addr", s_addr, RST_PC);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
